// File: rtl/alu_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu_pkg
// Description : Shared definitions for alu_mdu. It holds the opcode
//               encodings, the MDU FSM state type and the MDU-opcode detector.
// Config      : ALU_MDU_DIV_EN. When it is defined, DIVU (1101) counts as an
//               MDU opcode. When it is not defined, only MULTU counts.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_mdu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    // MULTU and DIVU share the upper three opcode bits.
    localparam logic [2:0] C_MDU_OP_PREFIX = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [3:0] op);
`ifdef ALU_MDU_DIV_EN
        return op[3:1] == C_MDU_OP_PREFIX;
`else
        return op == OP_MULTU;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : Iterative unsigned multiply/divide engine. It processes one
//               bit per cycle and produces the HI/LO result after WIDTH
//               iterations.
// Ports       : clk, rst_n (async, active-low)
//               i_start, i_op      - launch request and opcode
//               i_a, i_b           - operands, latched when a start is accepted
//               o_busy, o_done     - iterating / one-cycle result pulse
//               o_hi, o_lo         - architectural HI/LO registers
//               o_div_by_zero      - last accepted op was DIVU by zero
// Config      : ALU_MDU_DIV_EN enables the divider datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e       r_state;
    mdu_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_opnd;   // multiplicand or divisor
    logic [WIDTH-1:0] r_acc;    // partial-product high half or partial remainder
    logic [WIDTH-1:0] r_q;      // multiplier/product low half or dividend/quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept  = (r_state == IDLE) && i_start && is_mdu_op(i_op);
    assign w_last    = (r_cnt == CNT_LAST);
    // Shift-add step. Add the multiplicand when the multiplier LSB is set,
    // then shift the combined {carry, acc, q} value right by one.
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : '0);

`ifdef ALU_MDU_DIV_EN
    logic             r_dbz;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH:0]   w_div_diff;

    // Restoring step. Because the partial remainder stays below the divisor,
    // the trial value fits in WIDTH+1 bits, and the top bit of the difference
    // is a clean borrow flag. With a zero divisor every trial succeeds, so the
    // quotient becomes all ones and the dividend drains into the remainder.
    assign w_div_trial = {r_acc, r_q[WIDTH-1]};
    assign w_div_diff  = w_div_trial - {1'b0, r_opnd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= (i_op == OP_DIVU) && (i_b == '0);
        end
    end

    assign o_div_by_zero = r_dbz;
`else
    assign o_div_by_zero = 1'b0;
`endif

    always_comb begin
        w_acc_next = r_acc;
        w_q_next   = r_q;
        case (r_state)
            MUL: begin
                w_acc_next = w_mul_sum[WIDTH:1];
                w_q_next   = {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
`ifdef ALU_MDU_DIV_EN
            DIV: begin
                if (!w_div_diff[WIDTH]) begin
                    w_acc_next = w_div_diff[WIDTH-1:0];
                    w_q_next   = {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc_next = w_div_trial[WIDTH-1:0];
                    w_q_next   = {r_q[WIDTH-2:0], 1'b0};
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef ALU_MDU_DIV_EN
                    w_state_next = (i_op == OP_MULTU) ? MUL : DIV;
`else
                    w_state_next = MUL;
`endif
                end
            end
            MUL, DIV: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_cnt <= '0;
                r_acc <= '0;
                if (i_op == OP_MULTU) begin
                    r_opnd <= i_a;
                    r_q    <= i_b;
                end else begin
                    r_opnd <= i_b;
                    r_q    <= i_a;
                end
            end else if (o_busy) begin
                r_acc <= w_acc_next;
                r_q   <= w_q_next;
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                // HI/LO are loaded on the edge that enters DONE.
                if (w_last) begin
                    r_hi <= w_acc_next;
                    r_lo <= w_q_next;
                end
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu
// Description : Execute-stage ALU. It has single-cycle logic, arithmetic,
//               compare and shift operations, plus an iterative MULTU/DIVU
//               unit that writes HI/LO.
// Ports       : clk, rst_n (async, active-low)
//               src_a, src_b, alu_control - operands and opcode
//               start                     - MDU launch request
//               alu_result, zero          - combinational result and zero flag
//               busy, done, hi, lo, div_by_zero - MDU status and registers
// Config      : ALU_MDU_DIV_EN defined enables DIVU. When it is undefined,
//               1101 is invalid and div_by_zero is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_control,
    input  logic             start,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_result;

    assign w_shamt = src_b[SHAMT_W-1:0];

    mdu_seq #(
        .WIDTH(WIDTH)
    ) u_mdu_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_op         (alu_control),
        .i_a          (src_a),
        .i_b          (src_b),
        .o_busy       (busy),
        .o_done       (done),
        .o_hi         (hi),
        .o_lo         (lo),
        .o_div_by_zero(div_by_zero)
    );

    // MDU opcodes, 0101 and any disabled opcode fall through to zero.
    always_comb begin
        w_result = '0;
        case (alu_control)
            OP_AND:  w_result = src_a & src_b;
            OP_OR:   w_result = src_a | src_b;
            OP_ADD:  w_result = src_a + src_b;
            OP_XOR:  w_result = src_a ^ src_b;
            OP_NOR:  w_result = ~(src_a | src_b);
            OP_SUB:  w_result = src_a - src_b;
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLL:  w_result = src_a << w_shamt;
            OP_SRL:  w_result = src_a >> w_shamt;
            OP_SRA:  w_result = $signed(src_a) >>> w_shamt;
            OP_MFHI: w_result = hi;
            OP_MFLO: w_result = lo;
            default: w_result = '0;
        endcase
    end

    assign alu_result = w_result;
    assign zero       = (w_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mdu
// Description : Self-checking bench for alu_mdu with WIDTH = 32. A cycle-level
//               reference model is checked on every falling edge, and directed
//               vectors are checked against hand-computed literals.
// Config      : ALU_MDU_DIV_EN selects the divider tests or the
//               DIVU-ignored test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    localparam int W = 32;
`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic [3:0]    alu_control = 4'h0;
    logic          start = 1'b0;
    logic [W-1:0]  alu_result;
    logic          zero;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_by_zero;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .src_a(src_a), .src_b(src_b),
        .alu_control(alu_control), .start(start), .alu_result(alu_result),
        .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_alu(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] h,
                                               input logic [W-1:0] l);
        int          sh;
        logic [63:0] ext;
        sh  = int'(b[4:0]);
        ext = {{32{a[31]}}, a};
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a ^ b;
            4'h4: return ~(a | b);
            4'h6: return a - b;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return (a[31] != b[31]) ? {31'd0, a[31]} : ((a < b) ? 32'd1 : 32'd0);
            4'h9: return a << sh;
            4'hA: return a >> sh;
            4'hB: begin ext = ext >> sh; return ext[31:0]; end
            4'hE: return h;
            4'hF: return l;
            default: return 32'd0;
        endcase
    endfunction

    // m_left: cycles until the MDU is idle again. Busy while >= 2, done at 1.
    int           m_left = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_nhi = '0, m_nlo = '0;
    logic         m_dbz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] prod;
        if (!rst_n) begin
            m_left <= 0; m_hi <= '0; m_lo <= '0; m_dbz <= 1'b0;
        end else if (m_left == 0) begin
            if (start && alu_control == 4'hC) begin
                prod   = {32'd0, src_a} * {32'd0, src_b};
                m_nhi  <= prod[63:32];
                m_nlo  <= prod[31:0];
                m_dbz  <= 1'b0;
                m_left <= W + 1;
            end else if (start && DIV_EN && alu_control == 4'hD) begin
                if (src_b == 0) begin
                    m_nhi <= src_a; m_nlo <= '1; m_dbz <= 1'b1;
                end else begin
                    m_nhi <= src_a % src_b; m_nlo <= src_a / src_b; m_dbz <= 1'b0;
                end
                m_left <= W + 1;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_hi <= m_nhi;
                m_lo <= m_nlo;
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        e = model_alu(alu_control, src_a, src_b, m_hi, m_lo);
        chk("alu_result", alu_result, e);
        chk("zero", zero, (e == 0));
        chk("busy", busy, (m_left >= 2));
        chk("done", done, (m_left == 1));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_by_zero", div_by_zero, m_dbz);
        if (done === 1'b1) n_done++;
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #2;
        alu_control = op; src_a = a; src_b = b;
        #1;
    endtask

    // Launch an MDU op, scramble the operands afterwards, and stop at the done cycle.
    task automatic run_mdu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int bc, output bit got);
        @(posedge clk); #2;
        alu_control = op; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; src_a = 32'hDEADBEEF; src_b = 32'h5A5A5A5A; alu_control = 4'h0;
        bc = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else if (busy) bc++;
        end
        chk("done_seen", got, 1'b1);
    endtask

    typedef struct { logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; } vec_t;
    vec_t sweep[10] = '{
        '{4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF}, '{4'h1, 32'hF000_0000, 32'h0000_000F},
        '{4'h3, 32'hAAAA_AAAA, 32'hFFFF_0000}, '{4'h4, 32'h0000_0000, 32'h0000_0000},
        '{4'h6, 32'h0000_0000, 32'h0000_0001}, '{4'h9, 32'h0000_0003, 32'h0000_001F},
        '{4'hA, 32'h8000_0000, 32'h0000_0021}, '{4'h5, 32'h1234_5678, 32'h1111_1111},
        '{4'hC, 32'h0000_0005, 32'h0000_0006}, '{4'h8, 32'h0000_0005, 32'hFFFF_FFFF}
    };

    initial begin
        int  bc;
        bit  got;
        int  d0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dbz", div_by_zero, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Combinational sweep
        set_in(4'h2, 32'hFFFF_FFFF, 32'h1);
        chk("add_wrap", alu_result, 32'd0);
        chk("add_zero", zero, 1'b1);
        set_in(4'h8, 32'h8000_0000, 32'h1);
        chk("slt", alu_result, 32'd1);
        set_in(4'h7, 32'h8000_0000, 32'h1);
        chk("sltu", alu_result, 32'd0);
        set_in(4'hB, 32'h8000_0000, 32'd4);
        chk("sra", alu_result, 32'hF800_0000);
        set_in(4'h9, 32'h0000_0003, 32'h0000_0024);
        chk("sll_shamt_low_bits", alu_result, 32'h0000_0030);
        foreach (sweep[i]) set_in(sweep[i].op, sweep[i].a, sweep[i].b);

        // MULTU 0xFFFFFFFF x 2
        run_mdu(4'hC, 32'hFFFF_FFFF, 32'd2, bc, got);
        chk("mul_busy_cycles", bc, 64'd32);
        chk("mul_hi", hi, 32'd1);
        chk("mul_lo", lo, 32'hFFFF_FFFE);

`ifdef ALU_MDU_DIV_EN
        run_mdu(4'hD, 32'd100, 32'd7, bc, got);
        chk("div_lo", lo, 32'd14);
        chk("div_hi", hi, 32'd2);
        chk("div_dbz", div_by_zero, 1'b0);
        run_mdu(4'hD, 32'h1234, 32'd0, bc, got);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_dbz", div_by_zero, 1'b1);
        @(posedge clk); #2;
        alu_control = 4'hC; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("dbz_cleared", div_by_zero, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("mul_after_div0_lo", lo, 32'd15);
`else
        @(posedge clk); #2;
        alu_control = 4'hD; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("divu_ignored_busy", busy, 1'b0);
        chk("divu_result_zero", alu_result, 32'd0);
        repeat (3) @(negedge clk);
        chk("divu_ignored_busy_later", busy, 1'b0);
        chk("divu_no_dbz", div_by_zero, 1'b0);
`endif

        // Starts during busy and during done are ignored
        @(posedge clk); #2;
        d0 = n_done;
        alu_control = 4'hC; src_a = 32'h0001_0000; src_b = 32'h30; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        alu_control = 4'hC; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("ign_done_seen", got, 1'b1);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ign_busy_after_done", busy, 1'b0);
        chk("ign_single_done", n_done - d0, 64'd1);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'h0030_0000);
        set_in(4'hF, 32'd0, 32'd0);
        chk("mflo", alu_result, 32'h0030_0000);

        // Reset during iteration 10 of a MULTU
        @(posedge clk); #2;
        alu_control = 4'hC; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        bc = 0;
        for (int i = 0; i < 100 && bc < 10; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("rst_mid_reached", bc, 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        d0 = n_done;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_done", n_done - d0, 64'd0);
        chk("rst_mid_hi_held", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
